// File: rtl/hamming_block_decoder.sv
// Two-stage streaming decoder for per-nibble Hamming(7,4) protected words.
// Corrects one flipped bit per 4-bit block and keeps a saturating count of corrected words.
module hamming_block_decoder #(
    parameter int width       = 16,
    parameter int blocks      = width / 4,
    parameter int parity_bits = blocks * 3,
    parameter int cnt_width   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       in_data,
    input  logic [parity_bits-1:0] in_parity,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [width-1:0]       out_data,
    output logic [parity_bits-1:0] out_parity,
    output logic [blocks-1:0]      out_block_err,
    output logic                   out_corrected,
    output logic [cnt_width-1:0]   err_count,
    input  logic                   clear_count
);

    logic                   s1_valid;
    logic [width-1:0]       s1_data;
    logic [parity_bits-1:0] s1_parity;
    logic [parity_bits-1:0] s1_syn;

    logic                   s1_load;
    logic                   s2_load;
    logic [parity_bits-1:0] in_syn;
    logic [width-1:0]       corr_data;
    logic [parity_bits-1:0] corr_parity;
    logic [blocks-1:0]      block_err;

    // Returns {p2, p1, p0} for one data nibble.
    function automatic logic [2:0] calc_parity(input logic [3:0] d);
        return {d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3], d[0] ^ d[1] ^ d[2]};
    endfunction

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        in_syn = '0;
        for (int i = 0; i < blocks; i++) begin
            in_syn[i*3 +: 3] = in_parity[i*3 +: 3] ^ calc_parity(in_data[i*4 +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_parity <= '0;
            s1_syn    <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data   <= in_data;
                s1_parity <= in_parity;
                s1_syn    <= in_syn;
            end
        end
    end

    // Each syndrome names exactly one bit of its block to flip; blocks never interact.
    always_comb begin
        corr_data   = s1_data;
        corr_parity = s1_parity;
        block_err   = '0;
        for (int i = 0; i < blocks; i++) begin
            block_err[i] = |s1_syn[i*3 +: 3];
            case (s1_syn[i*3 +: 3])
                3'b111:  corr_data[i*4 + 0]   = ~s1_data[i*4 + 0];
                3'b011:  corr_data[i*4 + 1]   = ~s1_data[i*4 + 1];
                3'b101:  corr_data[i*4 + 2]   = ~s1_data[i*4 + 2];
                3'b110:  corr_data[i*4 + 3]   = ~s1_data[i*4 + 3];
                3'b001:  corr_parity[i*3 + 0] = ~s1_parity[i*3 + 0];
                3'b010:  corr_parity[i*3 + 1] = ~s1_parity[i*3 + 1];
                3'b100:  corr_parity[i*3 + 2] = ~s1_parity[i*3 + 2];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_parity    <= '0;
            out_block_err <= '0;
            out_corrected <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data      <= corr_data;
                out_parity    <= corr_parity;
                out_block_err <= block_err;
                out_corrected <= |block_err;
            end
        end
    end

    // Clear wins over a simultaneous corrected transfer.
    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_corrected && !(&err_count)) begin
            err_count <= err_count + cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_hamming_block_decoder.sv
// Directed bench for hamming_block_decoder: correction cases, latency, backpressure,
// counter saturation/clear and mid-stream reset, with a 4-bit counter to reach saturation.
module tb_hamming_block_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [11:0] in_parity;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [11:0] out_parity;
    logic [3:0]  out_block_err;
    logic        out_corrected;
    logic [3:0]  err_count;
    logic        clear_count;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    logic [3:0]  exp_cnt = '0;

    hamming_block_decoder #(
        .width(16),
        .cnt_width(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_parity(in_parity),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_parity(out_parity),
        .out_block_err(out_block_err),
        .out_corrected(out_corrected),
        .err_count(err_count),
        .clear_count(clear_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder used to build protected words for streaming tests.
    function automatic logic [11:0] enc(input logic [15:0] d);
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            p[i*3 + 2] = d[i*4] ^ d[i*4 + 2] ^ d[i*4 + 3];
            p[i*3 + 1] = d[i*4] ^ d[i*4 + 1] ^ d[i*4 + 3];
            p[i*3 + 0] = d[i*4] ^ d[i*4 + 1] ^ d[i*4 + 2];
        end
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [11:0] p);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_parity = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic receiveWord(input string tag, input logic [15:0] ed, input logic [11:0] ep,
                               input logic [3:0] eb);
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_data"}, 32'(out_data), 32'(ed));
        checkOutput({tag, "_parity"}, 32'(out_parity), 32'(ep));
        checkOutput({tag, "_blkerr"}, 32'(out_block_err), 32'(eb));
        checkOutput({tag, "_corr"}, 32'(out_corrected), 32'(eb != 4'd0));
        @(posedge clk);
        #1;
        if (eb != 4'd0 && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        checkOutput({tag, "_cnt"}, 32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] words [5];
        logic [11:0] pars  [5];
        logic [3:0]  errs  [5];
        int          sent;
        int          got;
        logic        fire_in;
        logic        fire_out;
        logic        saw_valid;
        int          n;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_parity = '0;
        out_ready = 1'b1;
        clear_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_parity", 32'(out_parity), 32'd0);
        checkOutput("rst_blk_err", 32'(out_block_err), 32'd0);
        checkOutput("rst_corrected", 32'(out_corrected), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] clean word and latency");
        applyStimulus(16'h1234, 12'hEE5);
        checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_two_edges", 32'(out_valid), 32'd1);
        receiveWord("clean", 16'h1234, 12'hEE5, 4'b0000);

        $display("[TB] single-bit corrections");
        applyStimulus(16'h1214, 12'hEE5);
        receiveWord("d1_blk1", 16'h1234, 12'hEE5, 4'b0010);
        applyStimulus(16'h1234, 12'hEE4);
        receiveWord("p0_blk0", 16'h1234, 12'hEE5, 4'b0001);
        applyStimulus(16'h0235, 12'hEE5);
        receiveWord("multi_blk", 16'h1234, 12'hEE5, 4'b1001);
        applyStimulus(16'h1234, 12'hFE5);
        receiveWord("p2_blk2", 16'h1234, 12'hEE5, 4'b0100);
        applyStimulus(16'h9234, 12'hEE5);
        receiveWord("d3_blk3", 16'h1234, 12'hEE5, 4'b1000);

        $display("[TB] backpressure");
        words[0] = 16'hBEEF; words[1] = 16'h0001; words[2] = 16'hA5A5;
        words[3] = 16'hFFFF; words[4] = 16'h7C30;
        errs[0] = 4'b0000; errs[1] = 4'b0000; errs[2] = 4'b0010;
        errs[3] = 4'b0000; errs[4] = 4'b0000;
        for (int k = 0; k < 5; k++) pars[k] = enc(words[k]);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_data   = (sent == 2) ? (words[sent] ^ 16'h0080) : words[sent];
                in_parity = pars[sent];
            end
            @(negedge clk);
            if (cyc == 3) begin
                checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                checkOutput("bp_accepts", 32'(sent), 32'd2);
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                checkOutput("bp_order_data", 32'(out_data), 32'(words[got]));
                checkOutput("bp_order_parity", 32'(out_parity), 32'(pars[got]));
                checkOutput("bp_blkerr", 32'(out_block_err), 32'(errs[got]));
                if (errs[got] != 4'd0 && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
                got++;
            end
            @(posedge clk);
            #1;
            if (fire_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_all_out", 32'(got), 32'd5);
        checkOutput("bp_cnt", 32'(err_count), 32'(exp_cnt));

        $display("[TB] counter saturation");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(16'h1214, 12'hEE5);
            receiveWord("sat", 16'h1234, 12'hEE5, 4'b0010);
        end
        checkOutput("sat_all_ones", 32'(err_count), 32'hF);

        $display("[TB] clear coincident with corrected transfer");
        applyStimulus(16'h0235, 12'hEE5);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("clr_valid", 32'(out_valid && out_corrected), 32'd1);
        clear_count = 1'b1;
        @(posedge clk);
        #1;
        clear_count = 1'b0;
        exp_cnt = '0;
        checkOutput("clr_priority", 32'(err_count), 32'd0);
        applyStimulus(16'h1214, 12'hEE5);
        receiveWord("after_clr", 16'h1234, 12'hEE5, 4'b0010);

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(16'h1214, 12'hEE5);
        applyStimulus(16'h0235, 12'hEE5);
        @(negedge clk);
        checkOutput("mid_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = '0;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_cnt", 32'(err_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("mid_no_stale", 32'(saw_valid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(16'h1234, 12'hEE5);
        receiveWord("post_rst", 16'h1234, 12'hEE5, 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
